// File: rtl/alu_issue_ctrl.sv
// Issue side of the 4-bit-ctrl ALU: decodes ALUOp/funct, registers operands,
// captures the ALU result and returns it over a valid/ready response port.
module alu_issue_ctrl #(
  parameter int          WIDTH        = 32,
  parameter logic [3:0]  ILLEGAL_CTRL = 4'b1111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_x,
  input  logic [WIDTH-1:0] src_y,
  output logic [3:0]       ctrl,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic             req_ready_q;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] x_q, y_q;
  logic             ill_q, ill_d;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;
  logic             rsp_ill_q;

  always_comb begin
    ctrl_d = ILLEGAL_CTRL;
    ill_d  = 1'b1;
    unique case (alu_op)
      2'b00: begin ctrl_d = 4'b0010; ill_d = 1'b0; end
      2'b01: begin ctrl_d = 4'b0110; ill_d = 1'b0; end
      2'b10: begin
        ill_d = 1'b0;
        case (funct)
          6'b100000: ctrl_d = 4'b0010;
          6'b100010: ctrl_d = 4'b0110;
          6'b100100: ctrl_d = 4'b0000;
          6'b100101: ctrl_d = 4'b0001;
          6'b101010: ctrl_d = 4'b0111;
          default: begin
            ctrl_d = ILLEGAL_CTRL;
            ill_d  = 1'b1;
          end
        endcase
      end
      2'b11: begin ctrl_d = ILLEGAL_CTRL; ill_d = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      ctrl_q      <= 4'b0000;
      x_q         <= '0;
      y_q         <= '0;
      ill_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_ill_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            ctrl_q      <= ctrl_d;
            x_q         <= src_x;
            y_q         <= src_y;
            ill_q       <= ill_d;
            req_ready_q <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          // Undecodable ops report a clean zero regardless of the ALU.
          rsp_data_q  <= ill_q ? '0 : alu_out;
          rsp_zero_q  <= ill_q ? 1'b1 : alu_zero;
          rsp_ill_q   <= ill_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign ctrl        = ctrl_q;
  assign x           = x_q;
  assign y           = y_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_illegal = rsp_ill_q;

endmodule
